// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encodings,
// frame length and default timing constants.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INHIBIT  = 4'd1,
    ST_START    = 4'd2,
    ST_DATA     = 4'd3,
    ST_PARITY   = 4'd4,
    ST_STOP     = 4'd5,
    ST_ACK      = 4'd6,
    ST_WAITIDLE = 4'd7
  } ps2_state_e;

  localparam int unsigned FRAME_FALLS            = 11;
  localparam int unsigned DEFAULT_INHIBIT_CYCLES = 2400;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 360000;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Width able to hold 0..max(a,b)-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a registered
// falling-edge pulse on the synchronized clock (pin-to-pulse lag of 3 cycles).
module ps2_edge_sync (
  input  logic clkk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall_pulse
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  always_ff @(posedge clkk) begin
    if (reset) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      clk_prev   <= 1'b1;
      dat_meta   <= 1'b1;
      dat_sync   <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      clk_meta   <= ps2_clk;
      clk_sync   <= clk_meta;
      clk_prev   <= clk_sync;
      dat_meta   <= ps2_dat;
      dat_sync   <= dat_meta;
      fall_pulse <= clk_prev & ~clk_sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 8 data
// bits, odd parity, stop, ACK sample). Optional watchdog: PS2TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clkk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CNT_W = cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);

  ps2_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] byte_q, byte_n;
  logic parity_q, parity_n;
  logic [2:0] idx, idx_n;
  logic dat_q, dat_n;
  logic nack_q, nack_n;
  logic done_n, error_n;
  logic clk_oe_c, dat_oe_c;

  logic clk_sync, dat_sync, fall_pulse;

  ps2_edge_sync u_sync (
    .clkk       (clkk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .fall_pulse (fall_pulse)
  );

  always_ff @(posedge clkk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      byte_q   <= '0;
      parity_q <= 1'b0;
      idx      <= '0;
      dat_q    <= 1'b0;
      nack_q   <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      byte_q   <= byte_n;
      parity_q <= parity_n;
      idx      <= idx_n;
      dat_q    <= dat_n;
      nack_q   <= nack_n;
      tx_done  <= done_n;
      tx_error <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    byte_n   = byte_q;
    parity_n = parity_q;
    idx_n    = idx;
    dat_n    = dat_q;
    nack_n   = nack_q;
    done_n   = 1'b0;
    error_n  = 1'b0;
    clk_oe_c = 1'b0;
    dat_oe_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tx_req) begin
          byte_n   = tx_data;
          parity_n = odd_parity(tx_data);
          cnt_n    = '0;
          state_n  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_c = 1'b1;
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          dat_oe_c = 1'b1;
          cnt_n    = '0;
          state_n  = ST_START;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_START: begin
        dat_oe_c = 1'b1;
        if (fall_pulse) begin
          idx_n   = '0;
          dat_n   = ~byte_q[0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        dat_oe_c = dat_q;
        if (fall_pulse) begin
          if (idx == 3'd7) begin
            dat_n   = ~parity_q;
            state_n = ST_PARITY;
          end else begin
            idx_n = idx + 3'd1;
            dat_n = ~byte_q[idx_n];
          end
        end
      end
      ST_PARITY: begin
        dat_oe_c = dat_q;
        if (fall_pulse) begin
          dat_n   = 1'b0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_pulse) begin
          nack_n  = dat_sync;
          state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_sync) state_n = ST_WAITIDLE;
      end
      ST_WAITIDLE: begin
        if (clk_sync && dat_sync) begin
          done_n  = ~nack_q;
          error_n = nack_q;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef PS2TX_TIMEOUT_EN
    // The inhibit counter is reused as the watchdog: it is cleared on START
    // entry and runs until the frame returns to IDLE.
    if (state != ST_IDLE && state != ST_INHIBIT) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_n = ST_IDLE;
        done_n  = 1'b0;
        error_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
`endif
  end

  assign ps2_clk_oe = clk_oe_c;
  assign ps2_dat_oe = dat_oe_c;
  assign tx_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
// Build with PS2TX_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned HALF       = 40;
  localparam int unsigned TB_INHIBIT = 2400;
  localparam int unsigned TB_TIMEOUT = 4000;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ack;
    logic       frame;
  } exp_t;

  logic       clkk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = '0;
  logic       ps2_clk, ps2_dat, ps2_clk_oe, ps2_dat_oe;
  logic       tx_busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic [9:0] dev_bits = '0;

  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  int   inh_run = 0;
  int   last_inh = 0;
  exp_t exp_q[$];

  assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

  always #5 clkk = ~clkk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (TB_INHIBIT),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clkk       (clkk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clkk);
    tx_req  = 1'b1;
    tx_data = d;
    @(negedge clkk);
    tx_req  = 1'b0;
  endtask

  // Device side: wait for request-to-send, then clock n_edges falling edges,
  // capturing the line on each rising edge and driving ACK when asked.
  task automatic device_frame(input int unsigned n_edges, input bit ack);
    int unsigned t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < 5000) begin
      @(negedge clkk);
      t++;
    end
    if (t >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL rts_wait: no request-to-send after %0d cycles, required within 5000", t);
      return;
    end
    for (int unsigned i = 0; i < n_edges; i++) begin
      repeat (HALF) @(negedge clkk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clkk);
      dev_clk_low = 1'b0;
      if (i < 10) dev_bits[i] = ps2_dat;
      if (i == 9) dev_dat_low = ack;
      if (i == 10) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned t = 0;
    while (tx_busy && t < 10000) begin
      @(negedge clkk);
      t++;
    end
    if (tx_busy) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, t);
    end
  endtask

  initial begin
    forever begin
      @(negedge clkk);
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
        last_inh = inh_run;
        inh_run  = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a completion pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkk);
      if (tx_done || tx_error) begin
        pulse_cnt++;
        chk("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
        chk("busy_at_pulse", {31'd0, tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b, required none", tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, tx_done, tx_error}, e.ack ? 32'd2 : 32'd1);
          if (e.frame) begin
            chk("data_bits", {24'd0, dev_bits[7:0]}, {24'd0, e.data});
            chk("parity_bit", {31'd0, dev_bits[8]}, {31'd0, e.parity});
            chk("stop_bit", {31'd0, dev_bits[9]}, 32'd1);
            chk("inhibit_len", last_inh, TB_INHIBIT);
          end
        end
      end
    end
  end

  initial begin
    int busy_seen;
    int pulses_before;
    repeat (5) @(negedge clkk);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done_err", {30'd0, tx_done, tx_error}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clkk);

    // 0xED acked, with a 0xFF request landing while busy
    exp_q.push_back('{data: 8'hED, parity: 1'b1, ack: 1'b1, frame: 1'b1});
    send(8'hED);
    repeat (100) @(negedge clkk);
    send(8'hFF);
    device_frame(FRAME_FALLS, 1'b1);
    wait_idle("frame_ed");
    busy_seen = 0;
    repeat (500) begin
      @(negedge clkk);
      if (tx_busy) busy_seen = 1;
    end
    chk("second_req_ignored", busy_seen, 0);

    // 0x02 acked: parity 0
    exp_q.push_back('{data: 8'h02, parity: 1'b0, ack: 1'b1, frame: 1'b1});
    send(8'h02);
    device_frame(FRAME_FALLS, 1'b1);
    wait_idle("frame_02");
    repeat (10) @(negedge clkk);

    // 0xAA with device NACK
    exp_q.push_back('{data: 8'hAA, parity: 1'b1, ack: 1'b0, frame: 1'b1});
    send(8'hAA);
    device_frame(FRAME_FALLS, 1'b0);
    wait_idle("frame_aa");
    repeat (10) @(negedge clkk);

    // Reset after four data bits of 0x0F (bit 4 = 0, so data is held low)
    send(8'h0F);
    device_frame(5, 1'b1);
    repeat (10) @(negedge clkk);
    chk("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
    chk("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    pulses_before = pulse_cnt;
    reset = 1'b1;
    @(negedge clkk);
    chk("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("midrst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clkk);
    chk("midrst_no_pulse", pulse_cnt - pulses_before, 0);

    // 0xF4 after the aborted frame
    exp_q.push_back('{data: 8'hF4, parity: 1'b0, ack: 1'b1, frame: 1'b1});
    send(8'hF4);
    device_frame(FRAME_FALLS, 1'b1);
    wait_idle("frame_f4");
    repeat (10) @(negedge clkk);

`ifdef PS2TX_TIMEOUT_EN
    begin
      int unsigned t = 0;
      exp_q.push_back('{data: 8'h11, parity: 1'b1, ack: 1'b0, frame: 1'b0});
      send(8'h11);
      while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < 5000) begin
        @(negedge clkk);
        t++;
      end
      t = 0;
      while (!tx_error && t < TB_TIMEOUT + 100) begin
        @(negedge clkk);
        t++;
      end
      chk("timeout_latency", t, TB_TIMEOUT);
      chk("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      chk("timeout_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
      repeat (10) @(negedge clkk);
      chk("pulse_total", pulse_cnt, 5);
    end
`else
    chk("pulse_total", pulse_cnt, 4);
`endif
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2400, clock-low inhibit time in clkk cycles (100 us at 24 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 360000, frame watchdog limit in clkk cycles (15 ms at 24 MHz).
REQ-003 SHALL use one clock and a synchronous active-high reset, with ports clkk and reset.
REQ-004 SHALL have port clkk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ps2_clk, input, 1, raw PS/2 clock line level.
REQ-007 SHALL have port ps2_dat, input, 1, raw PS/2 data line level.
REQ-008 SHALL have port ps2_clk_oe, output, 1, drives PS/2 clock low when 1, line released when 0.
REQ-009 SHALL have port ps2_dat_oe, output, 1, drives PS/2 data low when 1, line released when 0.
REQ-010 SHALL have port tx_req, input, 1, send request, sampled only in IDLE.
REQ-011 SHALL have port tx_data, input, 8, command byte, latched with tx_req.
REQ-012 SHALL have port tx_busy, output, 1, high from the cycle after acceptance until return to IDLE.
REQ-013 SHALL have port tx_done, output, 1, one-cycle pulse on successful ACK.
REQ-014 SHALL have port tx_error, output, 1, one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL pass ps2_clk and ps2_dat through a 2-FF synchronizer, and SHALL detect a falling clock edge as prev=1, cur=0 on the synchronized clock; fall_pulse SHALL lag the pin by 3 cycles.
REQ-016 SHALL implement the states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK and WAITIDLE.
REQ-017 IDLE: when tx_req=1, SHALL latch tx_data, compute the odd parity bit (~^tx_data), clear the counter and go to INHIBIT; ps2_clk_oe and ps2_dat_oe SHALL be 0.
REQ-018 INHIBIT: ps2_clk_oe SHALL be 1 for exactly INHIBIT_CYCLES cycles; ps2_dat_oe SHALL be asserted in the final cycle; the FSM SHALL then go to START.
REQ-019 START: ps2_clk_oe SHALL be 0 and ps2_dat_oe SHALL be 1 (start bit); the first fall_pulse SHALL go to DATA with ps2_dat_oe set to ~byte[0].
REQ-020 DATA: each fall_pulse SHALL advance a 3-bit index; after bit 7 has been driven, the next fall_pulse SHALL drive ~parity and go to PARITY.
REQ-021 PARITY: the next fall_pulse SHALL release data (ps2_dat_oe=0, stop bit) and go to STOP.
REQ-022 STOP: the next fall_pulse SHALL sample the synchronized data and go to ACK; data=0 is ACK, data=1 is NACK.
REQ-023 ACK/WAITIDLE: SHALL wait until the synchronized clock and data are both 1, then pulse tx_done (ACK) or tx_error (NACK) for one cycle and return to IDLE.
REQ-024 SHALL ignore tx_req while tx_busy=1, with no queuing.
REQ-025 tx_done and tx_error SHALL never assert in the same cycle.
REQ-026 A frame SHALL contain exactly 11 falling edges after START entry: 8 data, 1 parity, 1 stop, 1 ACK.

Reset
REQ-027 reset SHALL force the IDLE state, ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters=0 and synchronizers=1.
REQ-028 reset asserted mid-frame SHALL release both lines on the next clkk edge and SHALL emit no done or error pulse.

Configuration
REQ-029 With macro PS2TX_TIMEOUT_EN defined, a watchdog SHALL count from entry to START; if it reaches TIMEOUT_CYCLES before IDLE, the block SHALL release both lines, pulse tx_error and return to IDLE.
REQ-030 Without PS2TX_TIMEOUT_EN, no watchdog counter SHALL exist, and a silent device SHALL hold the FSM in its current state indefinitely.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the state encodings (4-bit), the frame length constant (11) and the default cycle constants.
REQ-032 One sub-module, ps2_edge_sync, SHALL provide synchronized levels and fall_pulse; ps2_host_tx SHALL instantiate it once.

Verification
REQ-033 Send tx_data=0xED with the device model acking -> the device sees data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1 and stop 1, and tx_done pulses once.
REQ-034 Send 0x02 -> parity bit 0, ps2_clk_oe high for exactly 2400 cycles, and tx_done pulses.
REQ-035 Device holds data high in the ACK slot -> tx_error pulses, tx_done stays 0, and the FSM returns to IDLE.
REQ-036 With PS2TX_TIMEOUT_EN, the device never clocks -> tx_error pulses 360000 cycles after START entry and both oe outputs are 0.
REQ-037 Assert reset after 4 data bits -> next cycle both oe=0 and tx_busy=0, with no done or error pulse; a subsequent 0xF4 send completes normally.
REQ-038 Pulse tx_req=1 with 0xFF while busy sending 0xED -> the second request is ignored, and exactly one frame (0xED) is seen.
